// File: rtl/mesh_agnt_pkg.sv
// Shared definitions for the mesh terminal agent: terminal-count derivation
// and packet field layout used by benches and monitors.
package mesh_agnt_pkg;

    // Packet header layout, measured downward from the packet MSB.
    localparam int NXT_JUMP_W = 8;
    localparam int ROW_W      = 4;
    localparam int COL_W      = 4;
    localparam int MODE_W     = 1;

    function automatic int calc_nterm(input int rows, input int cols);
        return 2 * rows + 2 * cols;
    endfunction

    function automatic int calc_tw(input int nterm);
        return (nterm > 1) ? $clog2(nterm) : 1;
    endfunction

    function automatic int nxt_jump_msb(input int pckg_sz);
        return pckg_sz - 1;
    endfunction

    function automatic int row_msb(input int pckg_sz);
        return pckg_sz - 1 - NXT_JUMP_W;
    endfunction

    function automatic int col_msb(input int pckg_sz);
        return pckg_sz - 1 - NXT_JUMP_W - ROW_W;
    endfunction

    function automatic int mode_bit(input int pckg_sz);
        return pckg_sz - 1 - NXT_JUMP_W - ROW_W - COL_W;
    endfunction

    function automatic int payload_msb(input int pckg_sz);
        return pckg_sz - 1 - NXT_JUMP_W - ROW_W - COL_W - MODE_W;
    endfunction

endpackage

// File: rtl/mesh_agnt_fifo.sv
// First-word fall-through transmit FIFO with full/pending flags and a sticky
// overflow flag; depth need not be a power of two.
module mesh_agnt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             pending,
    output logic             ovf,
    output logic [WIDTH-1:0] head
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign pending = (count != '0);
    assign head    = mem[rd_ptr];

    // A pop frees the slot a simultaneous write needs, so full+write+pop is legal.
    assign do_pop  = rd_en && pending;
    assign do_push = wr_en && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en && full && !do_pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mesh_term_agent.sv
// Boundary agent serving every terminal of the router mesh: per-terminal
// transmit FIFOs plus a round-robin receive arbiter. Optional macro
// MESH_AGNT_TS_EN adds a cycle counter and an rx_ts timestamp output.
module mesh_term_agent
    import mesh_agnt_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int pckg_sz    = 32,
    parameter int fifo_depth = 4,
    localparam int NTERM     = calc_nterm(ROWS, COLUMS),
    localparam int TW        = calc_tw(NTERM)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [TW-1:0]                 wr_term,
    input  logic [pckg_sz-1:0]            wr_data,
    output logic [NTERM-1:0]              wr_full,
    output logic [NTERM-1:0]              ovf,
    output logic [NTERM-1:0]              pndng,
    output logic [NTERM-1:0][pckg_sz-1:0] data_out,
    input  logic [NTERM-1:0]              popin,
    input  logic [NTERM-1:0]              pndng_i_in,
    input  logic [NTERM-1:0][pckg_sz-1:0] data_out_i_in,
    output logic [NTERM-1:0]              pop,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [TW-1:0]                 rx_term,
    output logic [pckg_sz-1:0]            rx_data
`ifdef MESH_AGNT_TS_EN
    ,
    output logic [31:0]                   rx_ts
`endif
);

    logic          wr_in_range;
    logic          can_take;
    logic          grant_any;
    logic          take;
    logic [TW-1:0] grant_idx;
    logic [TW-1:0] rr_ptr;

    // Out-of-range terminal indices only exist when NTERM is not a power of two.
    generate
        if (NTERM < (1 << TW)) begin : g_range_chk
            assign wr_in_range = (wr_term < TW'(NTERM));
        end else begin : g_range_full
            assign wr_in_range = 1'b1;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NTERM; i++) begin : g_tx
            mesh_agnt_fifo #(
                .WIDTH (pckg_sz),
                .DEPTH (fifo_depth)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr_en && wr_in_range && (wr_term == TW'(i))),
                .wr_data (wr_data),
                .rd_en   (popin[i]),
                .full    (wr_full[i]),
                .pending (pndng[i]),
                .ovf     (ovf[i]),
                .head    (data_out[i])
            );
        end
    endgenerate

    assign can_take = !rx_valid || rx_ready;
    assign take     = can_take && grant_any;

    // Scan upward from rr_ptr with wraparound; the first pending terminal wins.
    always_comb begin
        logic [TW:0]   sum;
        logic [TW-1:0] idx;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NTERM; k++) begin
            sum = {1'b0, rr_ptr} + (TW+1)'(k);
            if (sum >= (TW+1)'(NTERM)) sum = sum - (TW+1)'(NTERM);
            idx = sum[TW-1:0];
            if (!grant_any && pndng_i_in[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (take && !reset) pop[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_term  <= '0;
            rx_data  <= '0;
            rr_ptr   <= '0;
        end else if (take) begin
            rx_valid <= 1'b1;
            rx_term  <= grant_idx;
            rx_data  <= data_out_i_in[grant_idx];
            rr_ptr   <= (grant_idx == TW'(NTERM - 1)) ? '0 : grant_idx + TW'(1);
        end else if (rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef MESH_AGNT_TS_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            rx_ts     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (take) rx_ts <= cycle_cnt;
        end
    end
`else
    // Default build carries no timestamp path.
`endif

endmodule
